key_event: RTL and testbench
============================

KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive differing samples (range 2..255) required before a debounced key changes.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port raw_keys  input  16  undebounced key matrix from the keypad scanner, bit n = key n (0x0..0xF) pressed.
REQ-005 SHALL have port keys  output  16  debounced key state, registered.
REQ-006 SHALL have port key_query  input  4  key index for skip-if-pressed instructions.
REQ-007 SHALL have port key_pressed  output  1  combinational keys[key_query].
REQ-008 SHALL have port wait_req  input  1  level request from CPU for wait-for-key, held until ack.
REQ-009 SHALL have port wait_ack  output  1  one-cycle registered pulse; key_index valid in that cycle.
REQ-010 SHALL have port key_index  output  4  latched index of the key that satisfied the wait.

Function
REQ-011 SHALL keep one counter per key, width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-012 SHALL clear counter n at any edge where raw_keys[n] == keys[n].
REQ-013 SHALL increment counter n at each edge where raw_keys[n] != keys[n]; on the DEBOUNCE_CYCLES-th consecutive such edge, keys[n] SHALL invert and counter n SHALL clear.
REQ-014 SHALL treat keys independently; simultaneous changes on several keys SHALL all complete on the same edge.
REQ-015 SHALL register keys_prev <= keys each cycle; press event vector = keys & ~keys_prev.
REQ-016 SHALL implement FSM states IDLE, ARMED, RELEASE, ACK, HOLD.
REQ-017 IDLE: wait_req=1 -> ARMED; otherwise stay.
REQ-018 ARMED: wait_req=0 -> IDLE (abort, no ack); else on any press event latch key_index = lowest set event bit and go to RELEASE or ACK per REQ-027/028.
REQ-019 SHALL ignore keys already held when ARMED is entered; only press events after entry qualify.
REQ-020 RELEASE: wait_req=0 -> IDLE (abort); keys[key_index] == 0 -> ACK.
REQ-021 ACK: wait_ack=1 for exactly this cycle; next state HOLD if wait_req=1, else IDLE.
REQ-022 HOLD: stay until wait_req=0, then IDLE; guarantees one ack per request.
REQ-023 key_index SHALL hold its last latched value outside ACK; changes only on latch in ARMED.

Reset
REQ-024 rst_n=0 SHALL immediately force keys=0, keys_prev=0, all counters=0, key_index=0, wait_ack=0, state IDLE.
REQ-025 Reset assertion mid-debounce or mid-wait SHALL discard progress; no ack SHALL issue for the interrupted request.
REQ-026 After rst_n release, first state update SHALL occur on the next rising clk edge.

Configuration
REQ-027 With KEY_RELEASE_WAIT_EN defined: ARMED press event -> RELEASE; ack issues after the latched key is debounced-released (COSMAC-compatible).
REQ-028 Without KEY_RELEASE_WAIT_EN: ARMED press event -> ACK directly; RELEASE state unreachable and MAY be omitted.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 raw_keys=0x0010 held from edge 0 -> keys=0x0010 after edge 3 (4th edge), not earlier; key_query=4 -> key_pressed=1.
REQ-030 raw_keys bit 4 toggles 1,1,1,0,1,1,1,0 per edge -> keys stays 0x0000 throughout.
REQ-031 No macro: wait_req=1, then raw_keys=0x0300 held -> wait_ack pulse once, key_index=0x8, then HOLD until wait_req=0.
REQ-032 Macro defined: wait_req=1, key 0xA pressed then released, each held 10 cycles -> no ack during press, single ack with key_index=0xA 4 edges after release begins.
REQ-033 Key 0x2 held before wait_req=1 -> no ack; release and re-press key 0x2 -> ack with key_index=0x2.
REQ-034 rst_n pulsed low while in RELEASE with keys=0x0400 -> keys=0, wait_ack never asserted, state IDLE; wait_req held 1 re-arms cleanly.

Source files
------------

// File: rtl/key_event_if.sv
// Keypad/CPU signal bundle for key_event: raw matrix in, debounced keys and
// the wait-for-key handshake out.
interface key_event_if;
  // wait_req is a level the CPU raises and holds; the block answers with a
  // single-cycle wait_ack (key_index valid in that cycle). The CPU drops
  // wait_req afterwards, and no second ack issues until it is raised again.
  logic [15:0] raw_keys;
  logic [15:0] keys;
  logic [3:0]  key_query;
  logic        key_pressed;
  logic        wait_req;
  logic        wait_ack;
  logic [3:0]  key_index;
  logic [2:0]  state_dbg;

  modport master (
    output raw_keys, key_query, wait_req,
    input  keys, key_pressed, wait_ack, key_index, state_dbg
  );

  modport slave (
    input  raw_keys, key_query, wait_req,
    output keys, key_pressed, wait_ack, key_index, state_dbg
  );
endinterface

// File: rtl/key_event.sv
// 16-key debouncer with wait-for-key-press handshake.
// Define KEY_RELEASE_WAIT_EN to hold the ack until the chosen key is released.
module key_event #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic       clk,
  input logic       rst_n,
  key_event_if.slave bus
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_RELEASE = 3'd2,
    S_ACK     = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  logic [CW-1:0] cnt [16];
  logic [15:0]   keys_q;
  logic [15:0]   keys_prev;
  logic [15:0]   press_ev;
  state_t        state;
  state_t        state_next;
  logic          latch_en;
  logic [3:0]    lowest_idx;
  logic [3:0]    key_index_q;
  logic          wait_ack_q;

  // A counter only advances while the raw bit disagrees with the debounced
  // bit; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q <= '0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (bus.raw_keys[i] == keys_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]    <= '0;
          keys_q[i] <= ~keys_q[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) keys_prev <= '0;
    else        keys_prev <= keys_q;
  end

  assign press_ev = keys_q & ~keys_prev;

  // State register, plus the registered ack and latched key index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_ack_q  <= 1'b0;
      key_index_q <= '0;
    end else begin
      state      <= state_next;
      wait_ack_q <= (state_next == S_ACK);
      if (latch_en) key_index_q <= lowest_idx;
    end
  end

  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.wait_req) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (!bus.wait_req) begin
          state_next = S_IDLE;
        end else if (|press_ev) begin
          latch_en = 1'b1;
`ifdef KEY_RELEASE_WAIT_EN
          state_next = S_RELEASE;
`else
          state_next = S_ACK;
`endif
        end
      end
      S_RELEASE: begin
        if (!bus.wait_req)               state_next = S_IDLE;
        else if (!keys_q[key_index_q])   state_next = S_ACK;
      end
      S_ACK: begin
        state_next = bus.wait_req ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!bus.wait_req) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Lowest-numbered press wins when several keys land on the same edge.
  always_comb begin
    lowest_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (press_ev[i]) lowest_idx = 4'(i);
    end
  end

  always_comb begin
    bus.keys        = keys_q;
    bus.key_pressed = keys_q[bus.key_query];
    bus.wait_ack    = wait_ack_q;
    bus.key_index   = key_index_q;
    bus.state_dbg   = state;
  end

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event: directed scenarios plus random traffic
// compared against a sample-history reference model.
module tb_key_event;

  localparam int D = 4;
`ifdef KEY_RELEASE_WAIT_EN
  localparam bit REL_MODE = 1'b1;
`else
  localparam bit REL_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  key_event_if bus();

  key_event #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: debounced bit flips once the last D raw samples taken
  // since its previous flip all disagree with it.
  logic [15:0] hist [$];
  int          flip_at [16];
  logic [15:0] m_keys, m_keys_prev;
  logic        m_ack;
  logic [3:0]  m_idx;
  bit          m_armed, m_served, m_relw;

  task automatic model_clear();
    hist.delete();
    foreach (flip_at[i]) flip_at[i] = 0;
    m_keys = '0; m_keys_prev = '0; m_ack = 1'b0; m_idx = '0;
    m_armed = 1'b0; m_served = 1'b0; m_relw = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] ev, nk;
    int e;
    bit all_diff;
    if (!rst_n) begin
      model_clear();
      return;
    end
    ev = m_keys & ~m_keys_prev;
    m_ack = 1'b0;
    if (!bus.wait_req) begin
      m_armed = 1'b0; m_served = 1'b0; m_relw = 1'b0;
    end else if (m_served) begin
      m_served = 1'b1;
    end else if (m_relw) begin
      if (!m_keys[m_idx]) begin m_ack = 1'b1; m_served = 1'b1; m_relw = 1'b0; end
    end else if (m_armed) begin
      if (ev != 0) begin
        for (int i = 15; i >= 0; i--) if (ev[i]) m_idx = 4'(i);
        if (REL_MODE) m_relw = 1'b1;
        else begin m_ack = 1'b1; m_served = 1'b1; end
      end
    end else begin
      m_armed = 1'b1;
    end
    hist.push_back(bus.raw_keys);
    e = hist.size() - 1;
    nk = m_keys;
    for (int n = 0; n < 16; n++) begin
      if (e - flip_at[n] + 1 >= D) begin
        all_diff = 1'b1;
        for (int k = e - D + 1; k <= e; k++) if (hist[k][n] == m_keys[n]) all_diff = 1'b0;
        if (all_diff) begin nk[n] = ~m_keys[n]; flip_at[n] = e + 1; end
      end
    end
    m_keys_prev = m_keys;
    m_keys = nk;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.raw_keys = 16'hFFFF; bus.wait_req = 1'b1; bus.key_query = 4'h0;
    repeat (3) tick();
    n_cmp++; if (bus.keys !== 16'h0000) begin n_bad++; $display("FAIL reset_keys: got %h want 0000", bus.keys); end
    n_cmp++; if (bus.wait_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus.wait_ack); end
    n_cmp++; if (bus.key_index !== 4'h0) begin n_bad++; $display("FAIL reset_index: got %h want 0", bus.key_index); end
    bus.raw_keys = 16'h0000; bus.wait_req = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.keys !== 16'h0000) begin n_bad++; $display("FAIL post_reset_keys: got %h want 0000", bus.keys); end
  endtask

  task automatic test_debounce_hold();
    logic [15:0] exp_k;
    bus.raw_keys = 16'h0010; bus.key_query = 4'h4;
    for (int i = 0; i < D; i++) begin
      tick();
      exp_k = (i == D - 1) ? 16'h0010 : 16'h0000;
      n_cmp++; if (bus.keys !== exp_k) begin n_bad++; $display("FAIL debounce_edge%0d: got %h want %h", i, bus.keys, exp_k); end
      n_cmp++; if (bus.key_pressed !== exp_k[4]) begin n_bad++; $display("FAIL key_pressed_edge%0d: got %b want %b", i, bus.key_pressed, exp_k[4]); end
    end
    bus.raw_keys = 16'h0000;
    repeat (D + 1) tick();
    n_cmp++; if (bus.keys !== m_keys) begin n_bad++; $display("FAIL debounce_release: got %h want %h", bus.keys, m_keys); end
  endtask

  task automatic test_bounce();
    bit pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      bus.raw_keys = pat[i] ? 16'h0010 : 16'h0000;
      tick();
      n_cmp++; if (bus.keys !== 16'h0000) begin n_bad++; $display("FAIL bounce_step%0d: got %h want 0000", i, bus.keys); end
    end
    bus.raw_keys = 16'h0000;
    repeat (2) tick();
  endtask

  task automatic test_wait_two_keys();
    int acks_press = 0, acks_total = 0;
    bus.wait_req = 1'b1;
    tick();
    bus.raw_keys = 16'h0300;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_cmp++; if (bus.wait_ack !== m_ack) begin n_bad++; $display("FAIL two_keys_ack: got %b want %b", bus.wait_ack, m_ack); end
      if (bus.wait_ack === 1'b1) acks_press++;
    end
    bus.raw_keys = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if (bus.wait_ack !== m_ack) begin n_bad++; $display("FAIL two_keys_rel_ack: got %b want %b", bus.wait_ack, m_ack); end
      if (bus.wait_ack === 1'b1) acks_total++;
    end
    acks_total += acks_press;
    n_cmp++; if (acks_press !== (REL_MODE ? 0 : 1)) begin n_bad++; $display("FAIL two_keys_press_acks: got %0d want %0d", acks_press, REL_MODE ? 0 : 1); end
    n_cmp++; if (acks_total !== 1) begin n_bad++; $display("FAIL two_keys_total_acks: got %0d want 1", acks_total); end
    n_cmp++; if (bus.key_index !== 4'h8) begin n_bad++; $display("FAIL two_keys_index: got %h want 8", bus.key_index); end
    bus.wait_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_press_release();
    int ack_at = -1, ack_phase = -1, acks = 0;
    bus.wait_req = 1'b1;
    tick();
    for (int ph = 0; ph < 2; ph++) begin
      bus.raw_keys = (ph == 0) ? 16'h0400 : 16'h0000;
      for (int i = 0; i < 10; i++) begin
        tick();
        n_cmp++; if (bus.wait_ack !== m_ack) begin n_bad++; $display("FAIL press_release_ack: got %b want %b", bus.wait_ack, m_ack); end
        if (bus.wait_ack === 1'b1) begin
          acks++; ack_at = i; ack_phase = ph;
          n_cmp++; if (bus.key_index !== 4'hA) begin n_bad++; $display("FAIL press_release_index: got %h want a", bus.key_index); end
        end
      end
    end
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL press_release_count: got %0d want 1", acks); end
    n_cmp++; if (ack_phase !== (REL_MODE ? 1 : 0) || ack_at !== 4) begin
      n_bad++; $display("FAIL press_release_timing: got phase %0d edge %0d want phase %0d edge 4", ack_phase, ack_at, REL_MODE ? 1 : 0);
    end
    bus.wait_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_held_key();
    int acks_early = 0, acks = 0;
    bus.raw_keys = 16'h0004;
    repeat (D + 2) tick();
    bus.wait_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.wait_ack === 1'b1) acks_early++;
    end
    bus.raw_keys = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.wait_ack === 1'b1) acks_early++;
    end
    n_cmp++; if (acks_early !== 0) begin n_bad++; $display("FAIL held_key_early_acks: got %0d want 0", acks_early); end
    for (int ph = 0; ph < 2; ph++) begin
      bus.raw_keys = (ph == 0) ? 16'h0004 : 16'h0000;
      for (int i = 0; i < 12; i++) begin
        tick();
        n_cmp++; if (bus.wait_ack !== m_ack) begin n_bad++; $display("FAIL held_key_ack: got %b want %b", bus.wait_ack, m_ack); end
        if (bus.wait_ack === 1'b1) acks++;
      end
    end
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL held_key_acks: got %0d want 1", acks); end
    n_cmp++; if (bus.key_index !== 4'h2) begin n_bad++; $display("FAIL held_key_index: got %h want 2", bus.key_index); end
    bus.wait_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_wait();
    int acks = 0;
    int hold_n = REL_MODE ? D + 3 : 2;
    bus.wait_req = 1'b1;
    tick();
    bus.raw_keys = 16'h0400;
    repeat (hold_n) tick();
    n_cmp++; if (bus.keys !== m_keys) begin n_bad++; $display("FAIL mid_wait_keys: got %h want %h", bus.keys, m_keys); end
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (bus.keys !== 16'h0000) begin n_bad++; $display("FAIL async_reset_keys: got %h want 0000", bus.keys); end
    n_cmp++; if (bus.wait_ack !== 1'b0) begin n_bad++; $display("FAIL async_reset_ack: got %b want 0", bus.wait_ack); end
    repeat (2) tick();
    bus.raw_keys = 16'h0000;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.wait_ack === 1'b1) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL reset_interrupted_acks: got %0d want 0", acks); end
    for (int ph = 0; ph < 2; ph++) begin
      bus.raw_keys = (ph == 0) ? 16'h0020 : 16'h0000;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus.wait_ack === 1'b1) acks++;
      end
    end
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL rearm_acks: got %0d want 1", acks); end
    n_cmp++; if (bus.key_index !== 4'h5) begin n_bad++; $display("FAIL rearm_index: got %h want 5", bus.key_index); end
    bus.wait_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [15:0] raw;
    raw = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) raw = raw ^ (16'h0001 << $urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) bus.wait_req = ~bus.wait_req;
      bus.raw_keys = raw;
      bus.key_query = 4'($urandom_range(0, 15));
      tick();
      n_cmp++; if (bus.keys !== m_keys) begin n_bad++; $display("FAIL rand_keys@%0d: got %h want %h", i, bus.keys, m_keys); end
      n_cmp++; if (bus.key_pressed !== m_keys[bus.key_query]) begin n_bad++; $display("FAIL rand_key_pressed@%0d: got %b want %b", i, bus.key_pressed, m_keys[bus.key_query]); end
      n_cmp++; if (bus.wait_ack !== m_ack) begin n_bad++; $display("FAIL rand_ack@%0d: got %b want %b", i, bus.wait_ack, m_ack); end
      n_cmp++; if (bus.key_index !== m_idx) begin n_bad++; $display("FAIL rand_index@%0d: got %h want %h", i, bus.key_index, m_idx); end
    end
    bus.wait_req = 1'b0;
    bus.raw_keys = '0;
    repeat (D + 2) tick();
  endtask

  initial begin
    model_clear();
    bus.raw_keys = '0; bus.key_query = '0; bus.wait_req = 1'b0;
    test_reset();
    test_debounce_hold();
    test_bounce();
    test_wait_two_keys();
    test_press_release();
    test_held_key();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
